// File: rtl/snake_hardware_pio.sv
// rtl/snake_hardware_pio.sv - Avalon-MM GPIO: set/clr/toggle outputs, synchronised inputs, edge capture, masked irq
module snake_hardware_pio #(
  parameter int                   OUT_WIDTH   = 31,
  parameter int                   IN_WIDTH    = 8,
  parameter logic [OUT_WIDTH-1:0] RESET_VALUE = '0,
  parameter int                   SYNC_STAGES = 2,
  parameter int                   EDGE_TYPE   = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [2:0]           address,
  input  logic                 chipselect,
  input  logic                 write_n,
  input  logic [31:0]          writedata,
  output logic [31:0]          readdata,
  input  logic [IN_WIDTH-1:0]  in_port,
  output logic [OUT_WIDTH-1:0] out_port,
  output logic                 irq
);

  localparam int WW = $clog2(SYNC_STAGES + 2);

  logic [OUT_WIDTH-1:0]                    data_out_q, data_out_d;
  logic [IN_WIDTH-1:0]                     irq_mask_q, irq_mask_d;
  logic [IN_WIDTH-1:0]                     edge_cap_q, edge_cap_d;
  logic [IN_WIDTH-1:0]                     prev_q;
  logic [SYNC_STAGES-1:0][IN_WIDTH-1:0]    sync_q;
  logic [WW-1:0]                           warm_q, warm_d;

  logic                 wr;
  logic [OUT_WIDTH-1:0] wd_out;
  logic [IN_WIDTH-1:0]  wd_in;
  logic [IN_WIDTH-1:0]  sync_out;
  logic [IN_WIDTH-1:0]  edge_raw;
  logic [IN_WIDTH-1:0]  edge_det;
  logic [IN_WIDTH-1:0]  cap_clr;
  logic                 unused_wd;

  assign wr        = chipselect & ~write_n;
  assign wd_out    = writedata[OUT_WIDTH-1:0];
  assign wd_in     = writedata[IN_WIDTH-1:0];
  assign unused_wd = ^writedata;
  assign sync_out  = sync_q[SYNC_STAGES-1];

  always_comb begin
    edge_raw = '0;
    if (EDGE_TYPE == 0) begin
      edge_raw = sync_out & ~prev_q;
    end else if (EDGE_TYPE == 1) begin
      edge_raw = ~sync_out & prev_q;
    end else begin
      edge_raw = (sync_out & ~prev_q) ^ (~sync_out & prev_q);
    end
  end

  // Edges are ignored until the sync chain has flushed its reset contents.
  assign edge_det = (warm_q == '0) ? edge_raw : '0;
  assign warm_d   = (warm_q == '0) ? '0 : warm_q - WW'(1);
  assign cap_clr  = (wr && address == 3'd3) ? wd_in : '0;

  // A new edge overrides a concurrent clear of the same bit.
  assign edge_cap_d = (edge_cap_q & ~cap_clr) | edge_det;

  always_comb begin
    data_out_d = data_out_q;
    irq_mask_d = irq_mask_q;
    if (wr) begin
      case (address)
        3'd0:    data_out_d = wd_out;
        3'd2:    irq_mask_d = wd_in;
        3'd4:    data_out_d = data_out_q | wd_out;
        3'd5:    data_out_d = data_out_q & ~wd_out;
        3'd6:    data_out_d = data_out_q ^ wd_out;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q <= RESET_VALUE;
      irq_mask_q <= '0;
      edge_cap_q <= '0;
      prev_q     <= '0;
      sync_q     <= '0;
      warm_q     <= WW'(SYNC_STAGES + 1);
    end else begin
      data_out_q <= data_out_d;
      irq_mask_q <= irq_mask_d;
      edge_cap_q <= edge_cap_d;
      prev_q     <= sync_out;
      sync_q     <= {sync_q[SYNC_STAGES-2:0], in_port};
      warm_q     <= warm_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      3'd0:    readdata[OUT_WIDTH-1:0] = data_out_q;
      3'd1:    readdata[IN_WIDTH-1:0]  = sync_out;
      3'd2:    readdata[IN_WIDTH-1:0]  = irq_mask_q;
      3'd3:    readdata[IN_WIDTH-1:0]  = edge_cap_q;
      default: readdata = '0;
    endcase
  end

  assign out_port = data_out_q;
  assign irq      = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_snake_hardware_pio.sv
// tb/tb_snake_hardware_pio.sv - self-checking bench for snake_hardware_pio (rising and any-edge instances)
`timescale 1ns/1ps
module tb_snake_hardware_pio;

  localparam int        SYNC = 2;
  localparam logic [30:0] RV = 31'h0000_00A5;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] rd0, rd2;
  logic [30:0] out0, out2;
  logic        irq0, irq2;

  int n_checks = 0;
  int n_errors = 0;

  snake_hardware_pio #(.OUT_WIDTH(31), .IN_WIDTH(8), .RESET_VALUE(RV),
                       .SYNC_STAGES(SYNC), .EDGE_TYPE(0)) u0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd0),
    .in_port(in_port), .out_port(out0), .irq(irq0));

  snake_hardware_pio #(.OUT_WIDTH(31), .IN_WIDTH(8), .RESET_VALUE(RV),
                       .SYNC_STAGES(SYNC), .EDGE_TYPE(2)) u2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd2),
    .in_port(in_port), .out_port(out2), .irq(irq2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: history of sampled inputs plus edges-since-reset
  logic [30:0] m_out;
  logic [7:0]  m_mask, m_cap0, m_cap2;
  logic [7:0]  hist [0:SYNC];
  int          m_edges;
  logic        m_wr, m_ok;
  logic [7:0]  m_cur, m_prv, m_clr;

  assign m_wr  = chipselect & ~write_n;
  assign m_cur = hist[SYNC-1];
  assign m_prv = hist[SYNC];
  assign m_ok  = (m_edges >= SYNC + 1);
  assign m_clr = (m_wr && address == 3'd3) ? writedata[7:0] : 8'h00;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_out   <= RV;
      m_mask  <= 8'h00;
      m_cap0  <= 8'h00;
      m_cap2  <= 8'h00;
      m_edges <= 0;
      for (int k = 0; k <= SYNC; k++) hist[k] <= 8'h00;
    end else begin
      hist[0] <= in_port;
      for (int k = 1; k <= SYNC; k++) hist[k] <= hist[k-1];
      if (m_edges < 1000) m_edges <= m_edges + 1;
      m_cap0 <= (m_cap0 & ~m_clr) | (m_ok ? (m_cur & ~m_prv) : 8'h00);
      m_cap2 <= (m_cap2 & ~m_clr) | (m_ok ? (m_cur ^ m_prv) : 8'h00);
      if (m_wr) begin
        case (address)
          3'd0:    m_out <= writedata[30:0];
          3'd2:    m_mask <= writedata[7:0];
          3'd4:    m_out <= m_out | writedata[30:0];
          3'd5:    m_out <= m_out & ~writedata[30:0];
          3'd6:    m_out <= m_out ^ writedata[30:0];
          default: ;
        endcase
      end
    end
  end

  function automatic logic [31:0] exp_rd(input logic [2:0] a, input logic [7:0] cap);
    case (a)
      3'd0:    return {1'b0, m_out};
      3'd1:    return {24'h0, hist[SYNC-1]};
      3'd2:    return {24'h0, m_mask};
      3'd3:    return {24'h0, cap};
      default: return 32'h0;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    address = 3'd0; writedata = 32'h0; in_port = 8'h00;
    repeat (2) tick();
    n_checks++;
    if (out0 !== 31'hA5) begin n_errors++; $display("FAIL reset_out_port got %h want %h", out0, 31'hA5); end
    address = 3'd0; #0.1;
    n_checks++;
    if (rd0 !== 32'h0000_00A5) begin n_errors++; $display("FAIL reset_rd0 got %h want %h", rd0, 32'hA5); end
    n_checks++;
    if (irq0 !== 1'b0 || irq2 !== 1'b0) begin n_errors++; $display("FAIL reset_irq got %b%b want 00", irq0, irq2); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_data_out;
    logic [2:0]  ta [4] = '{3'd0, 3'd4, 3'd5, 3'd6};
    logic [31:0] td [4] = '{32'h0F, 32'hF0, 32'h03, 32'h81};
    logic [30:0] te [4] = '{31'h0F, 31'hFF, 31'hFC, 31'h7D};
    bus_write(3'd0, 32'hFFFF_FFFF);
    address = 3'd0; #0.1;
    n_checks++;
    if (out0 !== 31'h7FFF_FFFF || rd0 !== 32'h7FFF_FFFF) begin
      n_errors++; $display("FAIL data_out_full got out=%h rd=%h want 7fffffff", out0, rd0);
    end
    for (int i = 0; i < 4; i++) begin
      bus_write(ta[i], td[i]);
      n_checks++;
      if (out0 !== te[i] || out2 !== te[i]) begin
        n_errors++; $display("FAIL data_out_op%0d got %h/%h want %h", i, out0, out2, te[i]);
      end
    end
    for (int a = 4; a < 8; a++) begin
      address = 3'(a); #0.1;
      n_checks++;
      if (rd0 !== 32'h0) begin n_errors++; $display("FAIL read_wo_addr%0d got %h want 0", a, rd0); end
    end
  endtask

  task automatic test_edge_capture;
    bus_write(3'd3, 32'hFF);
    bus_write(3'd2, 32'h01);
    in_port = 8'h01;
    tick();
    address = 3'd1; #0.1;
    n_checks++;
    if (rd0[0] !== 1'b0) begin n_errors++; $display("FAIL data_in_edge1 got %b want 0", rd0[0]); end
    tick();
    address = 3'd1; #0.1;
    n_checks++;
    if (rd0[0] !== 1'b1) begin n_errors++; $display("FAIL data_in_edge2 got %b want 1", rd0[0]); end
    address = 3'd3; #0.1;
    n_checks++;
    if (rd0 !== 32'h0 || irq0 !== 1'b0) begin n_errors++; $display("FAIL cap_edge2 got %h irq %b want 0 0", rd0, irq0); end
    tick();
    address = 3'd3; #0.1;
    n_checks++;
    if (rd0 !== 32'h1 || irq0 !== 1'b1 || irq2 !== 1'b1) begin
      n_errors++; $display("FAIL cap_edge3 got %h irq %b%b want 1 11", rd0, irq0, irq2);
    end
    bus_write(3'd3, 32'h01);
    address = 3'd3; #0.1;
    n_checks++;
    if (rd0 !== 32'h0 || irq0 !== 1'b0 || irq2 !== 1'b0) begin
      n_errors++; $display("FAIL cap_clear got %h irq %b%b want 0 00", rd0, irq0, irq2);
    end
  endtask

  task automatic test_set_wins;
    in_port = 8'h05;
    tick();
    tick();
    bus_write(3'd3, 32'h04);
    address = 3'd3; #0.1;
    n_checks++;
    if (rd0 !== 32'h04 || rd2 !== 32'h04) begin
      n_errors++; $display("FAIL set_wins got %h/%h want 04", rd0, rd2);
    end
    bus_write(3'd3, 32'h04);
    address = 3'd3; #0.1;
    n_checks++;
    if (rd0 !== 32'h0) begin n_errors++; $display("FAIL set_wins_clear got %h want 0", rd0); end
  endtask

  task automatic test_warmup;
    in_port = 8'hFF;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (8) tick();
    address = 3'd3; #0.1;
    n_checks++;
    if (rd0 !== 32'h0 || rd2 !== 32'h0) begin
      n_errors++; $display("FAIL warmup_suppress got %h/%h want 0", rd0, rd2);
    end
    in_port = 8'h7F;
    repeat (3) tick();
    address = 3'd3; #0.1;
    n_checks++;
    if (rd2 !== 32'h80 || rd0 !== 32'h0) begin
      n_errors++; $display("FAIL any_edge_fall got %h/%h want 0/80", rd0, rd2);
    end
    bus_write(3'd3, 32'hFF);
    in_port = 8'hFF;
    repeat (3) tick();
    address = 3'd3; #0.1;
    n_checks++;
    if (rd2 !== 32'h80 || rd0 !== 32'h80) begin
      n_errors++; $display("FAIL any_edge_rise got %h/%h want 80/80", rd0, rd2);
    end
  endtask

  task automatic test_random;
    logic [31:0] e0, e2;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0) in_port = in_port ^ 8'($urandom);
      chipselect = 1'($urandom_range(0, 1));
      write_n    = 1'($urandom_range(0, 1));
      address    = 3'($urandom);
      writedata  = $urandom;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
      n_checks++;
      if (out0 !== m_out || out2 !== m_out) begin
        n_errors++; $display("FAIL rand_out cyc%0d got %h/%h want %h", i, out0, out2, m_out);
      end
      n_checks++;
      if (irq0 !== |(m_cap0 & m_mask) || irq2 !== |(m_cap2 & m_mask)) begin
        n_errors++; $display("FAIL rand_irq cyc%0d got %b%b want %b%b", i, irq0, irq2,
                             |(m_cap0 & m_mask), |(m_cap2 & m_mask));
      end
      address = 3'($urandom); #0.1;
      e0 = exp_rd(address, m_cap0);
      e2 = exp_rd(address, m_cap2);
      n_checks++;
      if (rd0 !== e0 || rd2 !== e2) begin
        n_errors++; $display("FAIL rand_read cyc%0d addr%0d got %h/%h want %h/%h", i, address, rd0, rd2, e0, e2);
      end
    end
  endtask

  task automatic test_async_reset;
    bus_write(3'd0, 32'h55);
    bus_write(3'd2, 32'hFF);
    in_port = 8'h00;
    repeat (3) tick();
    bus_write(3'd3, 32'hFF);
    in_port = 8'h01;
    repeat (3) tick();
    n_checks++;
    if (irq0 !== 1'b1 || out0 !== 31'h55) begin
      n_errors++; $display("FAIL pre_reset got irq %b out %h want 1 55", irq0, out0);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (out0 !== RV || out2 !== RV || irq0 !== 1'b0 || irq2 !== 1'b0) begin
      n_errors++; $display("FAIL async_reset got out %h irq %b%b want %h 00", out0, irq0, irq2, RV);
    end
    address = 3'd3; #0.1;
    n_checks++;
    if (rd0 !== 32'h0 || rd2 !== 32'h0) begin n_errors++; $display("FAIL async_reset_cap got %h/%h want 0", rd0, rd2); end
    address = 3'd2; #0.1;
    n_checks++;
    if (rd0 !== 32'h0) begin n_errors++; $display("FAIL async_reset_mask got %h want 0", rd0); end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_data_out();
    test_edge_capture();
    test_set_wins();
    test_warmup();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
